// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: opcode qualifiers,
// func3 op codes and FSM state encodings.
package muldiv_seq_pkg;

  localparam logic [6:0] OPC_R_R   = 7'b0110011;
  localparam logic [6:0] MULDIV_F7 = 7'b0000001;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shared adder drives a shift-add
// multiplier or a restoring divider, one bit per cycle, with a stall to the pipeline.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output md_state_e       state_dbg
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  // Handshake: start_i is taken in IDLE when flush_i is low; stall_o holds the
  // pipeline from that cycle until DONE, where done_o marks result_o valid.

  md_state_e       state, state_nxt;
  logic [CW-1:0]   count;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_mag_q, b_mag_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic [XLEN-1:0] result_q;
  logic            q_neg_q, r_neg_q;

  // ---------------- operand decode (IDLE) ----------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    a_signed = (func3_i == M_MUL) || (func3_i == M_MULH) || (func3_i == M_MULHSU) ||
               (func3_i == M_DIV) || (func3_i == M_REM);
    b_signed = (func3_i == M_MUL) || (func3_i == M_MULH) ||
               (func3_i == M_DIV) || (func3_i == M_REM);
    a_neg    = a_signed & op_a_i[XLEN-1];
    b_neg    = b_signed & op_b_i[XLEN-1];
    a_mag    = a_neg ? (~op_a_i + 1'b1) : op_a_i;
    b_mag    = b_neg ? (~op_b_i + 1'b1) : op_b_i;
    div_zero = func3_i[2] && (op_b_i == '0);
    div_ovf  = ((func3_i == M_DIV) || (func3_i == M_REM)) &&
               (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    fast     = div_zero | div_ovf;
    // Divide-by-zero and signed overflow bypass the iteration entirely.
    if (div_zero) fast_res = func3_i[1] ? op_a_i : '1;
    else          fast_res = func3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept   = (state == MD_IDLE) && start_i && !flush_i;
  end

  // ---------------- shared iterate datapath ----------------
  logic              is_div, cin;
  logic [XLEN:0]     shifted, add_x, add_y, sum;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  always_comb begin
    is_div  = f3_q[2];
    shifted = {hi_q, lo_q[XLEN-1]};
    // Divide subtracts the divisor via invert+carry; multiply adds the multiplicand.
    add_x   = is_div ? shifted : {1'b0, hi_q};
    add_y   = is_div ? ~{1'b0, b_mag_q} : (lo_q[0] ? {1'b0, a_mag_q} : '0);
    cin     = is_div;
    sum     = add_x + add_y + {{XLEN{1'b0}}, cin};
    if (is_div) begin
      // Partial remainder stays below the divisor, so sum[XLEN] is the borrow.
      if (!sum[XLEN]) begin
        hi_nxt = sum[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {hi_nxt, lo_nxt};
    prod_fix = q_neg_q ? (~prod + 1'b1) : prod;
    quo_fix  = q_neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
    rem_fix  = r_neg_q ? (~hi_nxt + 1'b1) : hi_nxt;
    case (f3_q)
      M_MUL:                     calc_res = prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             calc_res = quo_fix;
      default:                   calc_res = rem_fix;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_CALC;
      MD_CALC: if (count == LAST) state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush_i) state_nxt = MD_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      f3_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      count    <= '0;
      f3_q     <= func3_i;
      a_mag_q  <= a_mag;
      b_mag_q  <= b_mag;
      hi_q     <= '0;
      lo_q     <= func3_i[2] ? a_mag : b_mag;
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      if (fast) result_q <= fast_res;
    end else if ((state == MD_CALC) && !flush_i) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      count <= count + CW'(1);
      if (count == LAST) result_q <= calc_res;
    end
  end

  assign stall_o   = accept || (state == MD_CALC);
  assign busy_o    = (state != MD_IDLE);
  assign done_o    = (state == MD_DONE) && !flush_i;
  assign result_o  = result_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M results, latency, stall
// length, special cases, flush, mid-op reset and back-to-back starts.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  func3_i;
  logic [31:0] op_a_i, op_b_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  md_state_e   state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .func3_i(func3_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count cycles to done_o and cycles with stall_o high.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int  n;
    int  stalls;
    bit  seen;
    @(negedge clk);
    start_i = 1'b1; func3_i = f3; op_a_i = a; op_b_i = b;
    #1 stalls = stall_o ? 1 : 0;
    @(posedge clk);
    #1 start_i = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (stall_o) stalls++;
      if (done_o) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_stall"}, 32'(stalls), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1; start_i = 1'b0; func3_i = '0; op_a_i = '0; op_b_i = '0; flush_i = 1'b0;
    #1;
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(MD_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("mul",    M_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",   M_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",  M_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", M_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("div",    M_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    M_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   M_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   M_REMU,   32'd100,      32'd7,        32'd2,        33);
    run_op("divu0",  M_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    run_op("remu0",  M_REMU,   32'h1234,     32'd0,        32'h00001234, 1);
    run_op("removf", M_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("divovf", M_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush while the counter sits at 10.
    @(negedge clk);
    start_i = 1'b1; func3_i = M_DIV; op_a_i = 32'd100; op_b_i = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    seen = 1'b0;
    repeat (11) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("flush_pre_state", 32'(state_dbg), 32'(MD_CALC));
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    check("flush_state", 32'(state_dbg), 32'(MD_IDLE));
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    check("flush_done", {31'd0, done_o}, 32'd0);
    check("flush_result", result_o, 32'h80000000);
    flush_i = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("flush_no_done", {31'd0, seen}, 32'd0);
    run_op("post_flush", M_DIV, 32'd100, 32'd7, 32'd14, 33);

    // Reset asserted at counter 5.
    @(negedge clk);
    start_i = 1'b1; func3_i = M_MUL; op_a_i = 32'd3; op_b_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_state", 32'(state_dbg), 32'(MD_CALC));
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_dbg), 32'(MD_IDLE));
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("rst_no_done", {31'd0, seen}, 32'd0);

    // Back-to-back with start_i held high; operands change during DONE.
    @(negedge clk);
    start_i = 1'b1; func3_i = M_MUL; op_a_i = 32'd3; op_b_i = 32'd5;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    check("b2b_lat1", 32'(n), 32'd33);
    check("b2b_res1", result_o, 32'd15);
    op_a_i = 32'd6; op_b_i = 32'd7;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    check("b2b_gap", 32'(n), 32'd34);
    check("b2b_res2", result_o, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
